// File: rtl/fill_seq_ctrl_pkg.sv
// rtl/fill_seq_ctrl_pkg.sv - shared state encoding and BCD types for the filling sequencer
package fill_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BOT = 3'd1,
        ST_FILL     = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_BOX_FULL = 3'd4,
        ST_ALL_FULL = 3'd5,
        ST_PAUSE    = 3'd6
    } fill_state_t;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic bcd2_is_zero(input bcd_digit_t h, input bcd_digit_t l);
        return (h == 4'd0) && (l == 4'd0);
    endfunction

endpackage

// File: rtl/fill_seq_ctrl_bcd_cnt2.sv
// rtl/fill_seq_ctrl_bcd_cnt2.sv - two-digit BCD counter with clear, increment and equality compare
module bcd_cnt2
    import fill_seq_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    input  bcd_digit_t cmp_h,
    input  bcd_digit_t cmp_l,
    output bcd_digit_t q_h,
    output bcd_digit_t q_l,
    output logic       eq
);

    // Saturates at 99; the configured limits never exceed that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_h <= '0;
            q_l <= '0;
        end else if (clr) begin
            q_h <= '0;
            q_l <= '0;
        end else if (inc) begin
            if (q_l != 4'd9) begin
                q_l <= q_l + 4'd1;
            end else if (q_h != 4'd9) begin
                q_l <= '0;
                q_h <= q_h + 4'd1;
            end
        end
    end

    assign eq = (q_h == cmp_h) && (q_l == cmp_l);

endmodule

// File: rtl/fill_seq_ctrl.sv
// rtl/fill_seq_ctrl.sv - bottle filling sequencer: conveyor, nozzle valve, bottle/box BCD counts
module fill_seq_ctrl
    import fill_seq_ctrl_pkg::*;
#(
    parameter int DOSE_W     = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              start,
    input  logic              stop,
    input  logic              conti,
    input  logic              bot_sense,
    input  logic              flow_tick,
    input  logic [DOSE_W-1:0] dose,
    input  logic [3:0]        per_box_h,
    input  logic [3:0]        per_box_l,
    input  logic [3:0]        box_max_h,
    input  logic [3:0]        box_max_l,
    output logic              valve,
    output logic              conveyor,
    output logic [3:0]        now_h,
    output logic [3:0]        now_l,
    output logic [3:0]        box_h,
    output logic [3:0]        box_l,
    output logic              box_full,
    output logic              all_full,
    output logic              busy,
    output logic [2:0]        state
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    fill_state_t       st_q, st_d, ret_q, ret_d;
    logic [DOSE_W-1:0] dose_lat_q, dose_cnt_q, dose_cnt_d;
    logic [DOSE_W:0]   dose_sum;
    logic              dose_done;
    bcd_digit_t        per_box_lat_h, per_box_lat_l, box_max_lat_h, box_max_lat_l;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic              cfg_ok, cfg_load;
    logic              now_clr, now_inc, now_eq;
    logic              box_clr, box_inc, box_eq;

    assign cfg_ok = (dose != '0) && !bcd2_is_zero(per_box_h, per_box_l)
                    && !bcd2_is_zero(box_max_h, box_max_l);

    // One bit wider so a count already at dose plus a tick cannot wrap.
    assign dose_sum  = {1'b0, dose_cnt_q} + (DOSE_W + 1)'(flow_tick);
    assign dose_done = (dose_sum >= {1'b0, dose_lat_q});

    always_comb begin
        st_d       = st_q;
        ret_d      = ret_q;
        dose_cnt_d = dose_cnt_q;
        settle_d   = settle_q;
        cfg_load   = 1'b0;
        now_clr    = 1'b0;
        now_inc    = 1'b0;
        box_clr    = 1'b0;
        box_inc    = 1'b0;
        case (st_q)
            ST_IDLE, ST_ALL_FULL: begin
                if (start && cfg_ok) begin
                    cfg_load   = 1'b1;
                    now_clr    = 1'b1;
                    box_clr    = 1'b1;
                    dose_cnt_d = '0;
                    settle_d   = '0;
                    st_d       = ST_WAIT_BOT;
                end
            end
            ST_WAIT_BOT: begin
                if (stop) begin
                    ret_d = ST_WAIT_BOT;
                    st_d  = ST_PAUSE;
                end else if (bot_sense) begin
                    st_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (stop) begin
                    // The tick arriving with stop still counts; completion waits for resume.
                    ret_d      = ST_FILL;
                    st_d       = ST_PAUSE;
                    dose_cnt_d = dose_done ? dose_lat_q : dose_sum[DOSE_W-1:0];
                end else if (dose_done) begin
                    dose_cnt_d = '0;
                    now_inc    = 1'b1;
                    st_d       = ST_SETTLE;
                end else begin
                    dose_cnt_d = dose_sum[DOSE_W-1:0];
                end
            end
            ST_SETTLE: begin
                if (stop) begin
                    ret_d = ST_SETTLE;
                    st_d  = ST_PAUSE;
                end else if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    if (now_eq) begin
                        box_inc = 1'b1;
                        st_d    = ST_BOX_FULL;
                    end else begin
                        st_d = ST_WAIT_BOT;
                    end
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_BOX_FULL: begin
                if (box_eq) begin
                    st_d = ST_ALL_FULL;
                end else if (conti) begin
                    now_clr = 1'b1;
                    st_d    = ST_WAIT_BOT;
                end
            end
            ST_PAUSE: begin
                if (!stop) st_d = ret_q;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            st_q          <= ST_IDLE;
            ret_q         <= ST_IDLE;
            dose_cnt_q    <= '0;
            settle_q      <= '0;
            dose_lat_q    <= '0;
            per_box_lat_h <= '0;
            per_box_lat_l <= '0;
            box_max_lat_h <= '0;
            box_max_lat_l <= '0;
            valve         <= 1'b0;
            conveyor      <= 1'b0;
            box_full      <= 1'b0;
            all_full      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            st_q       <= st_d;
            ret_q      <= ret_d;
            dose_cnt_q <= dose_cnt_d;
            settle_q   <= settle_d;
            if (cfg_load) begin
                dose_lat_q    <= dose;
                per_box_lat_h <= per_box_h;
                per_box_lat_l <= per_box_l;
                box_max_lat_h <= box_max_h;
                box_max_lat_l <= box_max_l;
            end
            // Decoded from the next state so each flag lines up with the state register.
            valve    <= (st_d == ST_FILL);
            conveyor <= (st_d == ST_WAIT_BOT);
            box_full <= (st_d == ST_BOX_FULL);
            all_full <= (st_d == ST_ALL_FULL);
            busy     <= (st_d != ST_IDLE) && (st_d != ST_ALL_FULL);
        end
    end

    assign state = st_q;

    bcd_cnt2 u_now_cnt (
        .clk   (CLK),
        .rst_n (RST_n),
        .clr   (now_clr),
        .inc   (now_inc),
        .cmp_h (per_box_lat_h),
        .cmp_l (per_box_lat_l),
        .q_h   (now_h),
        .q_l   (now_l),
        .eq    (now_eq)
    );

    bcd_cnt2 u_box_cnt (
        .clk   (CLK),
        .rst_n (RST_n),
        .clr   (box_clr),
        .inc   (box_inc),
        .cmp_h (box_max_lat_h),
        .cmp_l (box_max_lat_l),
        .q_h   (box_h),
        .q_l   (box_l),
        .eq    (box_eq)
    );

endmodule

// File: tb/tb_fill_seq_ctrl.sv
// tb/tb_fill_seq_ctrl.sv - self-checking bench for fill_seq_ctrl
module tb_fill_seq_ctrl;

    localparam int DOSE_W     = 8;
    localparam int SETTLE_CYC = 4;

    logic              CLK = 1'b0;
    logic              RST_n;
    logic              start, stop, conti, bot_sense, flow_tick;
    logic [DOSE_W-1:0] dose;
    logic [3:0]        per_box_h, per_box_l, box_max_h, box_max_l;
    logic              valve, conveyor, box_full, all_full, busy;
    logic [3:0]        now_h, now_l, box_h, box_l;
    logic [2:0]        state;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_dose, m_per_box, m_box_max, m_now, m_box;

    fill_seq_ctrl #(.DOSE_W(DOSE_W), .SETTLE_CYC(SETTLE_CYC)) dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .stop(stop), .conti(conti),
        .bot_sense(bot_sense), .flow_tick(flow_tick), .dose(dose),
        .per_box_h(per_box_h), .per_box_l(per_box_l),
        .box_max_h(box_max_h), .box_max_l(box_max_l),
        .valve(valve), .conveyor(conveyor), .now_h(now_h), .now_l(now_l),
        .box_h(box_h), .box_l(box_l), .box_full(box_full), .all_full(all_full),
        .busy(busy), .state(state)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] bcd8(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic tick_clk();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_cfg(input int d, input int pb, input int bm);
        dose      = DOSE_W'(d);
        per_box_h = 4'(pb / 10);
        per_box_l = 4'(pb % 10);
        box_max_h = 4'(bm / 10);
        box_max_l = 4'(bm % 10);
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        start = 0; stop = 0; conti = 0; bot_sense = 0; flow_tick = 0;
        apply_cfg(0, 0, 0);
        repeat (2) @(posedge CLK);
        #1 RST_n = 1'b1;
    endtask

    task automatic run_start(input int d, input int pb, input int bm);
        apply_cfg(d, pb, bm);
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        m_dose = d; m_per_box = pb; m_box_max = bm; m_now = 0; m_box = 0;
        // Scramble the config inputs: only the values latched at start may matter.
        apply_cfg($urandom_range(1, 255), $urandom_range(1, 99), $urandom_range(1, 99));
        n_cmp++;
        if (state !== 3'd1 || busy !== 1'b1 || conveyor !== 1'b1 || {now_h, now_l, box_h, box_l} !== 16'h0) begin
            n_fail++;
            $display("FAIL run_start: state=%0d busy=%b conv=%b now=%h%h box=%h%h, want state=1 busy=1 conv=1 counts 0",
                     state, busy, conveyor, now_h, now_l, box_h, box_l);
        end
    endtask

    // One bottle from WAIT_BOT through SETTLE; pause_at is the tick index that carries stop (-1 = none).
    task automatic fill_bottle(input int pause_at);
        int waited, gaps, hold, n_set;
        bit bad;
        waited = 0;
        while (conveyor !== 1'b1 && waited < 50) begin
            tick_clk();
            waited++;
        end
        n_cmp++;
        if (conveyor !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_conveyor: conveyor=%b want 1 within 50 cycles", conveyor);
        end
        bot_sense = 1'b1;
        tick_clk();
        bot_sense = 1'b0;
        n_cmp++;
        if (state !== 3'd2 || valve !== 1'b1 || conveyor !== 1'b0) begin
            n_fail++;
            $display("FAIL enter_fill: state=%0d valve=%b conv=%b want 2/1/0", state, valve, conveyor);
        end
        for (int k = 0; k < m_dose; k++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                tick_clk();
                n_cmp++;
                if (valve !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fill_gap: valve=%b want 1 after %0d of %0d ticks", valve, k, m_dose);
                end
            end
            flow_tick = 1'b1;
            stop = (k == pause_at);
            tick_clk();
            flow_tick = 1'b0;
            if (k == pause_at) begin
                n_cmp++;
                if (state !== 3'd6 || valve !== 1'b0 || conveyor !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pause_enter: state=%0d valve=%b conv=%b want 6/0/0", state, valve, conveyor);
                end
                hold = $urandom_range(1, 3);
                for (int h = 0; h < hold; h++) begin
                    flow_tick = 1'($urandom_range(0, 1));
                    tick_clk();
                    n_cmp++;
                    if (state !== 3'd6 || valve !== 1'b0) begin
                        n_fail++;
                        $display("FAIL pause_hold: state=%0d valve=%b want 6/0", state, valve);
                    end
                end
                stop = 1'b0;
                flow_tick = 1'($urandom_range(0, 1));
                tick_clk();
                flow_tick = 1'b0;
                n_cmp++;
                if (state !== 3'd2 || valve !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pause_resume: state=%0d valve=%b want 2/1", state, valve);
                end
                if (k == m_dose - 1) tick_clk();
            end
            n_cmp++;
            if (k == m_dose - 1) begin
                if (state !== 3'd3 || valve !== 1'b0 || conveyor !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_done: state=%0d valve=%b conv=%b want 3/0/0 after %0d ticks", state, valve, conveyor, m_dose);
                end
            end else if (state !== 3'd2 || valve !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_mid: state=%0d valve=%b want 2/1 after %0d of %0d ticks", state, valve, k + 1, m_dose);
            end
        end
        m_now++;
        n_cmp++;
        if ({now_h, now_l} !== bcd8(m_now)) begin
            n_fail++;
            $display("FAIL now_inc: now=%h%h want %h", now_h, now_l, bcd8(m_now));
        end
        n_set = 0;
        bad = 1'b0;
        while (state === 3'd3 && n_set < 20) begin
            if (valve !== 1'b0 || conveyor !== 1'b0) bad = 1'b1;
            n_set++;
            tick_clk();
        end
        n_cmp++;
        if (n_set != SETTLE_CYC || bad) begin
            n_fail++;
            $display("FAIL settle_len: %0d cycles (outputs_low=%b) want %0d cycles low", n_set, !bad, SETTLE_CYC);
        end
        if (m_now == m_per_box) begin
            m_box++;
            n_cmp++;
            if (state !== 3'd4 || box_full !== 1'b1 || busy !== 1'b1 || {box_h, box_l} !== bcd8(m_box)) begin
                n_fail++;
                $display("FAIL box_full: state=%0d box_full=%b busy=%b box=%h%h want 4/1/1/%h",
                         state, box_full, busy, box_h, box_l, bcd8(m_box));
            end
            if (m_box == m_box_max) begin
                tick_clk();
                n_cmp++;
                if (state !== 3'd5 || all_full !== 1'b1 || box_full !== 1'b0 || busy !== 1'b0 || valve !== 1'b0 || conveyor !== 1'b0) begin
                    n_fail++;
                    $display("FAIL all_full: state=%0d all=%b boxf=%b busy=%b valve=%b conv=%b want 5/1/0/0/0/0",
                             state, all_full, box_full, busy, valve, conveyor);
                end
            end else begin
                start = 1'b1;
                tick_clk();
                start = 1'b0;
                n_cmp++;
                if (state !== 3'd4 || {box_h, box_l} !== bcd8(m_box)) begin
                    n_fail++;
                    $display("FAIL start_in_box_full: state=%0d box=%h%h want 4/%h", state, box_h, box_l, bcd8(m_box));
                end
                conti = 1'b1;
                tick_clk();
                conti = 1'b0;
                m_now = 0;
                n_cmp++;
                if (state !== 3'd1 || conveyor !== 1'b1 || {now_h, now_l} !== 8'h00) begin
                    n_fail++;
                    $display("FAIL conti: state=%0d conv=%b now=%h%h want 1/1/00", state, conveyor, now_h, now_l);
                end
            end
        end else begin
            n_cmp++;
            if (state !== 3'd1 || conveyor !== 1'b1) begin
                n_fail++;
                $display("FAIL next_bottle: state=%0d conv=%b want 1/1", state, conveyor);
            end
        end
    endtask

    task automatic run_job(input int d, input int pb, input int bm, input int pause_pct);
        int pause_at;
        run_start(d, pb, bm);
        for (int b = 0; b < pb * bm; b++) begin
            pause_at = ($urandom_range(0, 99) < pause_pct) ? $urandom_range(0, d - 1) : -1;
            fill_bottle(pause_at);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({state, valve, conveyor, box_full, all_full, busy} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: state=%0d valve=%b conv=%b boxf=%b all=%b busy=%b want all 0",
                     state, valve, conveyor, box_full, all_full, busy);
        end
        n_cmp++;
        if ({now_h, now_l, box_h, box_l} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_counts: now=%h%h box=%h%h want 0000", now_h, now_l, box_h, box_l);
        end
    endtask

    task automatic test_zero_config();
        int cfgs[3][3] = '{'{3, 0, 1}, '{0, 5, 1}, '{3, 5, 0}};
        for (int i = 0; i < 3; i++) begin
            apply_cfg(cfgs[i][0], cfgs[i][1], cfgs[i][2]);
            start = 1'b1;
            tick_clk();
            start = 1'b0;
            tick_clk();
            n_cmp++;
            if (state !== 3'd0 || busy !== 1'b0 || conveyor !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_cfg_%0d: state=%0d busy=%b conv=%b want 0/0/0", i, state, busy, conveyor);
            end
        end
    endtask

    task automatic test_basic_run();
        run_job(3, 2, 1, 0);
        n_cmp++;
        if (all_full !== 1'b1 || {box_h, box_l} !== 8'h01 || {now_h, now_l} !== 8'h02) begin
            n_fail++;
            $display("FAIL basic_run_end: all=%b box=%h%h now=%h%h want 1/01/02", all_full, box_h, box_l, now_h, now_l);
        end
    endtask

    task automatic test_box_rollover();
        run_job(2, 12, 2, 0);
    endtask

    task automatic test_stop_resume();
        run_start(5, 1, 1);
        fill_bottle(1);
        run_start(2, 1, 1);
        fill_bottle(1);
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 3; r++)
            run_job($urandom_range(1, 6), $urandom_range(1, 12), $urandom_range(1, 3), 30);
    endtask

    task automatic test_conti_and_reset_mid_fill();
        run_start(4, 3, 1);
        conti = 1'b1;
        tick_clk();
        conti = 1'b0;
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        n_cmp++;
        if (state !== 3'd1 || conveyor !== 1'b1 || {now_h, now_l} !== 8'h00) begin
            n_fail++;
            $display("FAIL conti_ignored: state=%0d conv=%b now=%h%h want 1/1/00", state, conveyor, now_h, now_l);
        end
        fill_bottle(-1);
        bot_sense = 1'b1;
        tick_clk();
        bot_sense = 1'b0;
        flow_tick = 1'b1;
        tick_clk();
        flow_tick = 1'b0;
        n_cmp++;
        if (valve !== 1'b1 || {now_h, now_l} !== 8'h01) begin
            n_fail++;
            $display("FAIL pre_reset_fill: valve=%b now=%h%h want 1/01", valve, now_h, now_l);
        end
        #2 RST_n = 1'b0;
        #1;
        n_cmp++;
        if (valve !== 1'b0 || state !== 3'd0 || conveyor !== 1'b0 || busy !== 1'b0 || {now_h, now_l, box_h, box_l} !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: valve=%b state=%0d conv=%b busy=%b now=%h%h box=%h%h want all 0",
                     valve, state, conveyor, busy, now_h, now_l, box_h, box_l);
        end
        tick_clk();
        RST_n = 1'b1;
        tick_clk();
        n_cmp++;
        if (state !== 3'd0 || valve !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: state=%0d valve=%b want 0/0", state, valve);
        end
    endtask

    initial begin
        test_reset();
        test_zero_config();
        test_basic_run();
        test_box_rollover();
        test_stop_resume();
        test_random_runs();
        test_conti_and_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fill_seq_ctrl.md
FILL_SEQ_CTRL -- requirements
Module: fill_seq_ctrl

Interface
REQ-001 Parameter DOSE_W, default 8: width of the fill-dose counter and of the dose input.
REQ-002 Parameter SETTLE_CYC, default 4: cycles the valve stays shut before the conveyor restarts.
REQ-003 CLK  input  1  system clock, rising edge.
REQ-004 RST_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 start  input  1  begin a run; 1-cycle pulse, honoured only in IDLE.
REQ-006 stop  input  1  pause request; level, sampled each cycle.
REQ-007 conti  input  1  1-cycle pulse: continue to the next box after a box fills.
REQ-008 bot_sense  input  1  bottle under nozzle; synchronous level.
REQ-009 flow_tick  input  1  flow-meter pulse; one cycle per dose unit.
REQ-010 dose  input  DOSE_W  flow ticks per bottle, binary.
REQ-011 per_box_h, per_box_l  input  4 each  bottles per box, BCD 01..99.
REQ-012 box_max_h, box_max_l  input  4 each  boxes per run, BCD 01..99.
REQ-013 valve  output  1  nozzle valve open.
REQ-014 conveyor  output  1  conveyor running.
REQ-015 now_h, now_l  output  4 each  bottles filled in current box, BCD.
REQ-016 box_h, box_l  output  4 each  completed boxes, BCD.
REQ-017 box_full, all_full, busy  output  1 each  status flags.
REQ-018 state  output  3  current FSM state encoding.

Function
REQ-019 States: IDLE=0, WAIT_BOT=1, FILL=2, SETTLE=3, BOX_FULL=4, ALL_FULL=5, PAUSE=6; all outputs registered.
REQ-020 IDLE: on start, latch dose, per_box, box_max; clear now and box counts; go WAIT_BOT; start ignored if any latched value is zero (stays IDLE).
REQ-021 WAIT_BOT: conveyor=1, valve=0; on bot_sense=1 go FILL next cycle with conveyor=0.
REQ-022 FILL: valve=1, conveyor=0; each flow_tick increments the dose counter; the cycle the counter reaches latched dose, go SETTLE and increment now (BCD, l carries into h).
REQ-023 SETTLE: valve=0, conveyor=0 for exactly SETTLE_CYC cycles, then evaluate: now==per_box -> BOX_FULL, else WAIT_BOT.
REQ-024 BOX_FULL: box_full=1, conveyor=0; increment box count on entry; if box==box_max go ALL_FULL, else wait for conti, then clear now and go WAIT_BOT.
REQ-025 ALL_FULL: all_full=1, valve=0, conveyor=0; stays until reset or start (start re-runs per REQ-020).
REQ-026 busy=1 in every state except IDLE and ALL_FULL.
REQ-027 stop=1 in WAIT_BOT, FILL or SETTLE -> PAUSE next cycle; valve and conveyor 0; dose counter and settle timer frozen; return to the interrupted state when stop=0.
REQ-028 flow_tick while not in FILL (including PAUSE) ignored; flow_tick on the same cycle as stop in FILL is counted.
REQ-029 stop has priority over the dose-complete transition in the same cycle; completion re-evaluated on resume.
REQ-030 conti outside BOX_FULL ignored; start outside IDLE/ALL_FULL ignored.
REQ-031 Input changes to dose/per_box/box_max mid-run have no effect until next start.
REQ-032 BCD counters never exceed 99; no wrap needed since limits cap at 99.

Reset
REQ-033 RST_n low: state=IDLE; valve, conveyor, box_full, all_full, busy=0; now, box, dose counter, settle timer, latched config = 0; applies immediately, including mid-FILL (valve closes asynchronously).

Structure
REQ-034 Shared package holds state encoding enum and a BCD-digit typedef.
REQ-035 One sub-module bcd_cnt2 (two-digit BCD counter: clear, inc, equality compare), instantiated twice (now, box).

Verification
REQ-036 dose=3, per_box=02, box_max=01: start, two bottles with 3 ticks each -> valve high 3 ticks per bottle, now 01 then 02, all_full=1, box=01.
REQ-037 per_box=12: fill 12 bottles -> now_l wraps 9->0 with now_h 0->1, box_full=1; conti -> now=00, WAIT_BOT.
REQ-038 stop asserted after 2 of 5 ticks -> PAUSE, valve=0, ticks ignored; release -> FILL, 3 more ticks complete bottle.
REQ-039 RST_n low mid-FILL -> valve=0 same cycle, state=IDLE, all counters 0.
REQ-040 start with per_box=00 -> stays IDLE, busy=0; conti in WAIT_BOT -> no effect.
REQ-041 SETTLE_CYC=4: count cycles from dose-complete to conveyor=1 -> exactly 4 cycles valve and conveyor low.
